// File: rtl/fp_align_stage.sv
// ============================================================================
// Module   : fp_align_stage
// Purpose  : FP32 adder align stage - order operands, restore hidden bits,
//            right-shift smaller significand with G/R/S, resolve specials.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fp_align_stage #(
  parameter int          SHIFT_SAT = 26,
  parameter logic [31:0] QNAN      = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        signA,
  input  logic        signB,
  input  logic [7:0]  exponentA,
  input  logic [7:0]  exponentB,
  input  logic [22:0] mantissaA,
  input  logic [22:0] mantissaB,
  input  logic        Ainf,
  input  logic        ANaN,
  input  logic        Asub,
  input  logic        Azero,
  input  logic        Anormal,
  input  logic        Binf,
  input  logic        BNaN,
  input  logic        Bsub,
  input  logic        Bzero,
  input  logic        Bnormal,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sign_big,
  output logic [7:0]  exp_big,
  output logic [23:0] mant_big,
  output logic [26:0] mant_small,
  output logic        eff_sub,
  output logic        special,
  output logic [31:0] special_result
);

  localparam logic [7:0] SAT_AMT = 8'(SHIFT_SAT);

  logic        s1_valid, s2_valid;
  logic        adv1, adv2;

  logic        s1_sign_big, s1_eff_sub, s1_special;
  logic [7:0]  s1_exp_big, s1_diff;
  logic [23:0] s1_sig_big, s1_sig_small;
  logic [31:0] s1_special_result;

  logic [7:0]  eff_a, eff_b;
  logic [23:0] sig_a, sig_b;
  logic        a_big;
  logic        sp_next;
  logic [31:0] sp_res_next;

  logic [26:0] ext, shifted, shift_mask;
  logic [26:0] small_next;

  assign adv2     = !s2_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;
  assign out_valid = s2_valid;

  // Subnormals and zeros share the minimum effective exponent of 1.
  assign eff_a = (Asub || Azero) ? 8'd1 : exponentA;
  assign eff_b = (Bsub || Bzero) ? 8'd1 : exponentB;
  assign sig_a = {Anormal, mantissaA};
  assign sig_b = {Bnormal, mantissaB};
  assign a_big = (eff_a > eff_b) || ((eff_a == eff_b) && (sig_a >= sig_b));

  always_comb begin
    sp_next     = 1'b0;
    sp_res_next = 32'h0;
    if (ANaN || BNaN) begin
      sp_next     = 1'b1;
      sp_res_next = QNAN;
    end else if (Ainf && Binf && (signA != signB)) begin
      sp_next     = 1'b1;
      sp_res_next = QNAN;
    end else if (Ainf || Binf) begin
      sp_next     = 1'b1;
      sp_res_next = {(Ainf ? signA : signB), 8'hFF, 23'h0};
    end else if (Azero && Bzero) begin
      sp_next     = 1'b1;
      sp_res_next = {signA & signB, 31'h0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid          <= 1'b0;
      s1_sign_big       <= 1'b0;
      s1_exp_big        <= 8'h0;
      s1_diff           <= 8'h0;
      s1_sig_big        <= 24'h0;
      s1_sig_small      <= 24'h0;
      s1_eff_sub        <= 1'b0;
      s1_special        <= 1'b0;
      s1_special_result <= 32'h0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign_big       <= a_big ? signA : signB;
        s1_exp_big        <= a_big ? eff_a : eff_b;
        s1_diff           <= a_big ? (eff_a - eff_b) : (eff_b - eff_a);
        s1_sig_big        <= a_big ? sig_a : sig_b;
        s1_sig_small      <= a_big ? sig_b : sig_a;
        s1_eff_sub        <= signA ^ signB;
        s1_special        <= sp_next;
        s1_special_result <= sp_res_next;
      end
    end
  end

  // Bits shifted past the LSB collapse into the sticky position.
  assign ext        = {s1_sig_small, 3'b000};
  assign shifted    = ext >> s1_diff;
  assign shift_mask = ~({27{1'b1}} << s1_diff);

  always_comb begin
    if (s1_diff >= SAT_AMT) begin
      small_next = {26'h0, |s1_sig_small};
    end else begin
      small_next = {shifted[26:1], shifted[0] | (|(ext & shift_mask))};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid       <= 1'b0;
      sign_big       <= 1'b0;
      exp_big        <= 8'h0;
      mant_big       <= 24'h0;
      mant_small     <= 27'h0;
      eff_sub        <= 1'b0;
      special        <= 1'b0;
      special_result <= 32'h0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        sign_big       <= s1_sign_big;
        exp_big        <= s1_exp_big;
        mant_big       <= s1_sig_big;
        mant_small     <= small_next;
        eff_sub        <= s1_eff_sub;
        special        <= s1_special;
        special_result <= s1_special_result;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_align_stage.sv
// ============================================================================
// Module   : tb_fp_align_stage
// Purpose  : Self-checking bench for fp_align_stage against an FP32-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fp_align_stage;

  typedef struct packed {
    logic        sign_big;
    logic [7:0]  exp_big;
    logic [23:0] mant_big;
    logic [26:0] mant_small;
    logic        eff_sub;
    logic        special;
    logic [31:0] special_result;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [31:0] opa, opb;

  logic        sign_big, eff_sub, special;
  logic [7:0]  exp_big;
  logic [23:0] mant_big;
  logic [26:0] mant_small;
  logic [31:0] special_result;

  logic a_inf, a_nan, a_sub, a_zero, a_norm;
  logic b_inf, b_nan, b_sub, b_zero, b_norm;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  assign a_zero = (opa[30:23] == 8'h00) && (opa[22:0] == 23'h0);
  assign a_sub  = (opa[30:23] == 8'h00) && (opa[22:0] != 23'h0);
  assign a_inf  = (opa[30:23] == 8'hFF) && (opa[22:0] == 23'h0);
  assign a_nan  = (opa[30:23] == 8'hFF) && (opa[22:0] != 23'h0);
  assign a_norm = (opa[30:23] != 8'h00) && (opa[30:23] != 8'hFF);
  assign b_zero = (opb[30:23] == 8'h00) && (opb[22:0] == 23'h0);
  assign b_sub  = (opb[30:23] == 8'h00) && (opb[22:0] != 23'h0);
  assign b_inf  = (opb[30:23] == 8'hFF) && (opb[22:0] == 23'h0);
  assign b_nan  = (opb[30:23] == 8'hFF) && (opb[22:0] != 23'h0);
  assign b_norm = (opb[30:23] != 8'h00) && (opb[30:23] != 8'hFF);

  fp_align_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .signA(opa[31]), .signB(opb[31]),
    .exponentA(opa[30:23]), .exponentB(opb[30:23]),
    .mantissaA(opa[22:0]), .mantissaB(opb[22:0]),
    .Ainf(a_inf), .ANaN(a_nan), .Asub(a_sub), .Azero(a_zero), .Anormal(a_norm),
    .Binf(b_inf), .BNaN(b_nan), .Bsub(b_sub), .Bzero(b_zero), .Bnormal(b_norm),
    .out_valid(out_valid), .out_ready(out_ready),
    .sign_big(sign_big), .exp_big(exp_big), .mant_big(mant_big),
    .mant_small(mant_small), .eff_sub(eff_sub),
    .special(special), .special_result(special_result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, expv);
    end
  endtask

  // Reference: classify, order by magnitude, align with arithmetic shift and remainder.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    int unsigned ea, eb, ma, mb, effa, effb, siga, sigb, sbig, ssmall, d;
    logic sa, sb, na, nb, ia, ib, za, zb, a_is_big;
    longint unsigned ext;
    sa = a[31]; sb = b[31];
    ea = a[30:23]; eb = b[30:23]; ma = a[22:0]; mb = b[22:0];
    na = (ea == 255) && (ma != 0); nb = (eb == 255) && (mb != 0);
    ia = (ea == 255) && (ma == 0); ib = (eb == 255) && (mb == 0);
    za = (ea == 0) && (ma == 0);   zb = (eb == 0) && (mb == 0);
    effa = (ea == 0) ? 1 : ea;     effb = (eb == 0) ? 1 : eb;
    siga = ((ea != 0 && ea != 255) ? 32'h800000 : 0) + ma;
    sigb = ((eb != 0 && eb != 255) ? 32'h800000 : 0) + mb;
    a_is_big = (effa > effb) || (effa == effb && siga >= sigb);
    r.sign_big = a_is_big ? sa : sb;
    r.exp_big  = 8'(a_is_big ? effa : effb);
    sbig       = a_is_big ? siga : sigb;
    ssmall     = a_is_big ? sigb : siga;
    d          = a_is_big ? effa - effb : effb - effa;
    r.mant_big = 24'(sbig);
    ext = longint'(ssmall) * 8;
    if (d >= 26) r.mant_small = (ssmall != 0) ? 27'd1 : 27'd0;
    else r.mant_small = 27'((ext >> d) | ((ext % (64'd1 << d)) != 0 ? 1 : 0));
    r.eff_sub = sa ^ sb;
    r.special = 1'b1;
    if (na || nb)                  r.special_result = 32'h7FC00000;
    else if (ia && ib && sa != sb) r.special_result = 32'h7FC00000;
    else if (ia || ib)             r.special_result = {(ia ? sa : sb), 8'hFF, 23'h0};
    else if (za && zb)             r.special_result = {sa & sb, 31'h0};
    else begin
      r.special = 1'b0;
      r.special_result = 32'h0;
    end
    return r;
  endfunction

  // Scoreboard: push on accepted input, compare on accepted output.
  always @(negedge clk) begin
    if (!reset) begin
      if (in_valid && in_ready) q.push_back(model(opa, opb));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_out", {31'h0, out_valid}, 32'h0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("sign_big",   {31'h0, sign_big},   {31'h0, e.sign_big});
          check("exp_big",    {24'h0, exp_big},    {24'h0, e.exp_big});
          check("mant_big",   {8'h0, mant_big},    {8'h0, e.mant_big});
          check("mant_small", {5'h0, mant_small},  {5'h0, e.mant_small});
          check("eff_sub",    {31'h0, eff_sub},    {31'h0, e.eff_sub});
          check("special",    {31'h0, special},    {31'h0, e.special});
          check("special_res", special_result,     e.special_result);
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    bit ok = 0;
    opa = a; opb = b; in_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
    end
    if (!ok) check("send_timeout", {31'h0, in_ready}, 32'h1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", q.size(), 32'h0);
  endtask

  function automatic logic [31:0] rand_op(input int unsigned base);
    int unsigned k, e;
    logic [22:0] m;
    k = $urandom_range(0, 11);
    m = 23'($urandom);
    e = base + $urandom_range(0, 60);
    e = (e < 30) ? 1 : e - 30;
    if (e > 254) e = 254;
    if ($urandom_range(0, 3) == 0) m = '0;
    case (k)
      0:       return {1'($urandom), 31'h0};
      1:       return {1'($urandom), 8'h00, (m == 0) ? 23'h1 : m};
      2:       return {1'($urandom), 8'hFF, 23'h0};
      3:       return {1'($urandom), 8'hFF, (m == 0) ? 23'h400000 : m};
      default: return {1'($urandom), 8'(e), m};
    endcase
  endfunction

  initial begin
    logic [31:0] va[8];
    logic [31:0] vb[8];
    logic [31:0] bpa[4];
    int acc, sent, base;
    bit  ok;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; opa = '0; opb = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_in_ready",  {31'h0, in_ready},  32'h1);
    check("rst_special",   {31'h0, special},   32'h0);
    reset = 1'b0;

    va = '{32'h3F800000, 32'hBF800000, 32'h4B800000, 32'h4E800000,
           32'h7FC00001, 32'h7F800000, 32'h00000000, 32'h80000000};
    vb = '{32'h40000000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
           32'h3F800000, 32'hFF800000, 32'h80000000, 32'h80000000};
    for (int i = 0; i < 8; i++) send(va[i], vb[i]);
    drain();

    // Two-cycle latency with no stall.
    opa = 32'h3F800000; opb = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    check("lat_cyc1", {31'h0, out_valid}, 32'h0);
    @(posedge clk); #1;
    check("lat_cyc2", {31'h0, out_valid}, 32'h1);
    drain();

    // Backpressure: only two pairs fit while the output is stalled.
    bpa = '{32'h3F800000, 32'h40400000, 32'h40800000, 32'h40A00000};
    out_ready = 1'b0; acc = 0;
    opa = bpa[0]; opb = 32'h3F000000; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      if (ok) begin acc++; if (acc < 4) opa = bpa[acc]; end
    end
    check("bp_accepts", acc, 32'd2);
    check("bp_in_ready", {31'h0, in_ready}, 32'h0);
    check("bp_out_valid", {31'h0, out_valid}, 32'h1);
    out_ready = 1'b1;
    for (int i = 0; i < 40 && acc < 4; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      if (ok) begin acc++; if (acc < 4) opa = bpa[acc]; end
    end
    in_valid = 1'b0;
    check("bp_total", acc, 32'd4);
    drain();

    // Reset with both stages full.
    out_ready = 1'b0;
    send(32'h41000000, 32'h3F800000);
    send(32'h42000000, 32'h3F800000);
    check("pre_rst_valid", {31'h0, out_valid}, 32'h1);
    check("pre_rst_ready", {31'h0, in_ready},  32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
    check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
    check("mid_rst_ready", {31'h0, in_ready},  32'h1);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Randomized traffic with random backpressure.
    sent = 0;
    base = $urandom_range(0, 254);
    opa = rand_op(base); opb = rand_op(base);
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 5000 && sent < 400; cyc++) begin
      @(negedge clk);
      ok = in_valid && in_ready;
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (ok) sent++;
      if (ok || !in_valid) begin
        base = $urandom_range(0, 254);
        opa = rand_op(base); opb = rand_op(base);
        in_valid = (sent < 400) && ($urandom_range(0, 4) != 0);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("rand_sent", sent, 32'd400);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
